// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake, ps2 pin levels and drive enables for ps2_host_tx
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       done;
    logic       err;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, done, err
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, ps2_clk_oe, ps2_data_oe, done, err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 byte transmitter with device ACK check
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int REQ_CYCLES     = 100,
    parameter int START_TIMEOUT  = 1500000,
    parameter int BIT_TIMEOUT    = 200000,
    parameter int FILTER_LEN     = 8
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus
);
    localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int WD_MAX = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int WD_W   = $clog2(WD_MAX + 1);
    localparam int FL_W   = $clog2(FILTER_LEN + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic            clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic            filt_q;
    logic [FL_W-1:0] fcnt_q;
    logic            fall;

    logic [2:0]      state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [WD_W-1:0] wd_q, wd_d, wd_limit;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      byte_q, byte_d;
    logic            par_q, par_d;
    logic            nack_q, nack_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            abort;

    // Filtered level only moves after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
            filt_q    <= 1'b1;
            fcnt_q    <= '0;
        end else begin
            clk_s1_q  <= bus.ps2_clk_in;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= bus.ps2_data_in;
            data_s2_q <= data_s1_q;
            if (clk_s2_q != filt_q) begin
                if (fcnt_q == FL_W'(FILTER_LEN - 1)) begin
                    filt_q <= clk_s2_q;
                    fcnt_q <= '0;
                end else begin
                    fcnt_q <= fcnt_q + FL_W'(1);
                end
            end else begin
                fcnt_q <= '0;
            end
        end
    end

    assign fall     = filt_q & ~clk_s2_q & (fcnt_q == FL_W'(FILTER_LEN - 1));
    assign wd_limit = (state_q == S_SEND && bit_q == 4'd0) ? WD_W'(START_TIMEOUT) : WD_W'(BIT_TIMEOUT);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        wd_d      = wd_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        par_d     = par_q;
        nack_d    = nack_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = err_q;
        abort     = 1'b0;
        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (bus.tx_valid) begin
                    byte_d    = bus.tx_data;
                    par_d     = ~^bus.tx_data;
                    nack_d    = 1'b0;
                    phase_d   = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (phase_q == PH_W'(INHIBIT_CYCLES - 1)) begin
                    phase_d   = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_REQ: begin
                if (phase_q == PH_W'(REQ_CYCLES - 1)) begin
                    clk_oe_d = 1'b0;
                    wd_d     = '0;
                    bit_d    = 4'd0;
                    state_d  = S_SEND;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_SEND: begin
                if (fall) begin
                    wd_d  = '0;
                    bit_d = bit_q + 4'd1;
                    if (bit_q < 4'd8) begin
                        data_oe_d = ~byte_q[bit_q[2:0]];
                    end else if (bit_q == 4'd8) begin
                        data_oe_d = ~par_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end else if (wd_q == wd_limit) begin
                    abort = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_ACK: begin
                if (fall) begin
                    nack_d  = data_s2_q;
                    wd_d    = '0;
                    state_d = S_WAIT_IDLE;
                end else if (wd_q == wd_limit) begin
                    abort = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (filt_q && data_s2_q) begin
                    done_d  = 1'b1;
                    err_d   = nack_q;
                    state_d = S_DONE;
                end else if (wd_q == wd_limit) begin
                    abort = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Any timeout releases both lines and reports a failed transfer.
        if (abort) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
            state_d   = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            wd_q      <= '0;
            bit_q     <= 4'd0;
            byte_q    <= 8'd0;
            par_q     <= 1'b0;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            wd_q      <= wd_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            par_q     <= par_d;
            nack_q    <= nack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.tx_ready    = (state_q == S_IDLE);
    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a wired-AND PS/2 device model
module tb_ps2_host_tx;
    localparam int INH = 40;
    localparam int REQ = 10;
    localparam int STO = 300;
    localparam int BTO = 200;
    localparam int FL  = 8;
    localparam int H   = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    int   tick = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   inh_cnt = 0;
    int   req_cnt = 0;
    int   done_cnt = 0;
    int   fall_tick = 0;
    logic start_bit;
    logic [9:0] rx_bits;

    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    assign bus.ps2_clk_in  = dev_clk & ~bus.ps2_clk_oe;
    assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .REQ_CYCLES    (REQ),
        .START_TIMEOUT (STO),
        .BIT_TIMEOUT   (BTO),
        .FILTER_LEN    (FL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always @(posedge clk) tick <= tick + 1;

    always @(negedge clk) begin
        if (bus.ps2_clk_oe && !bus.ps2_data_oe) inh_cnt++;
        if (bus.ps2_clk_oe && bus.ps2_data_oe) req_cnt++;
        if (bus.done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] b, output int t_acc);
        @(posedge clk);
        #1 bus.tx_data = b;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        t_acc = tick;
    endtask

    task automatic dev_frame(input int nf, input logic ack_lvl, input bit glitch);
        int w;
        w = 0;
        @(negedge clk);
        while (!(!bus.ps2_clk_oe && bus.ps2_data_oe) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("rts_seen", 32'(w < 2000), 1);
        repeat (H) @(posedge clk);
        #1 start_bit = bus.ps2_data_in;
        for (int n = 1; n <= nf; n++) begin
            if (n == 11) dev_data = ack_lvl;
            @(posedge clk);
            #1 dev_clk = 1'b0;
            fall_tick = tick;
            repeat (H) @(posedge clk);
            #1 dev_clk = 1'b1;
            if (n <= 10) rx_bits[n-1] = bus.ps2_data_in;
            if (n == 11) dev_data = 1'b1;
            if (n != nf) begin
                if (glitch && n == 5) begin
                    repeat (12) @(posedge clk);
                    #1 dev_clk = 1'b0;
                    repeat (3) @(posedge clk);
                    #1 dev_clk = 1'b1;
                    repeat (H - 15) @(posedge clk);
                end else begin
                    repeat (H) @(posedge clk);
                end
            end
        end
    endtask

    task automatic wait_done(output int t_done, output logic e);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.done && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("done_seen", 32'(bus.done), 1);
        check("clk_oe_at_done", 32'(bus.ps2_clk_oe), 0);
        check("data_oe_at_done", 32'(bus.ps2_data_oe), 0);
        t_done = tick;
        e = bus.err;
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 0);
        check("ready_after_done", 32'(bus.tx_ready), 1);
    endtask

    task automatic run_xfer(input logic [7:0] b, input logic ack, input bit gl, input logic exp_par);
        int ta, td, i0, r0;
        logic e;
        i0 = inh_cnt;
        r0 = req_cnt;
        check("ready_before", 32'(bus.tx_ready), 1);
        start_tx(b, ta);
        check("ready_drop", 32'(bus.tx_ready), 0);
        dev_frame(11, ack, gl);
        wait_done(td, e);
        check("inhibit_len", 32'(inh_cnt - i0), INH);
        check("req_len", 32'(req_cnt - r0), REQ);
        check("start_bit", 32'(start_bit), 0);
        check("wire_byte", 32'(rx_bits[7:0]), 32'(b));
        check("parity_bit", 32'(rx_bits[8]), 32'(exp_par));
        check("stop_bit", 32'(rx_bits[9]), 1);
        check("err", 32'(e), 32'(ack));
    endtask

    initial begin
        int ta, td, d0;
        logic e;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.tx_ready), 1);
        check("rst_clk_oe", 32'(bus.ps2_clk_oe), 0);
        check("rst_data_oe", 32'(bus.ps2_data_oe), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // 0xF4 with ACK: wire bits 0,0,1,0,1,1,1,1, parity 0
        run_xfer(8'hF4, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);

        // 0xFF, device NACKs: parity 1, err 1
        run_xfer(8'hFF, 1'b1, 1'b0, 1'b1);
        repeat (5) @(posedge clk);

        // 0x00 with a silent device: start timeout
        start_tx(8'h00, ta);
        wait_done(td, e);
        check("start_timeout_cycles", 32'(td - ta), INH + REQ + STO + 1);
        check("start_timeout_err", 32'(e), 1);
        repeat (5) @(posedge clk);

        // Device stalls after 5 falls: bit timeout measured from the last pin fall
        start_tx(8'hA5, ta);
        dev_frame(5, 1'b0, 1'b0);
        wait_done(td, e);
        check("bit_timeout_cycles", 32'(td - fall_tick), 3 + FL + BTO);
        check("bit_timeout_err", 32'(e), 1);
        repeat (5) @(posedge clk);

        // Reset after fall 4: lines released at once, no done pulse
        start_tx(8'hF4, ta);
        dev_frame(4, 1'b0, 1'b0);
        d0 = done_cnt;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_clk_oe", 32'(bus.ps2_clk_oe), 0);
        check("rst_mid_data_oe", 32'(bus.ps2_data_oe), 0);
        check("rst_mid_ready", 32'(bus.tx_ready), 1);
        repeat (50) @(negedge clk);
        check("rst_mid_no_done", 32'(done_cnt - d0), 0);
        run_xfer(8'hF4, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);

        // 3-cycle clock glitch mid-frame must not advance the bit index
        run_xfer(8'h5A, 1'b0, 1'b1, 1'b1);
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
